wb_stage: RTL and testbench

- Writeback stage of the RISC-V32I pipeline. Sits directly upstream of the register file and drives its write port (waddr/wdata/wr_en).
- ALU results are retired with a registered 1-cycle latency.
- Loads are handled by a small FSM: it issues a data-memory read, waits for the response, and aligns and sign/zero-extends the data before writeback.
- Asserts stall_o toward execute while a load is outstanding.

---
 rtl/rv32_pkg.sv | 21 ++
 rtl/wb_load_align.sv | 54 +++++
 rtl/wb_stage.sv | 162 ++++++++++++++++
 tb/tb_wb_stage.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// rv32_pkg: shared RV32I constants for the writeback stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rv32_pkg;

    localparam int XLEN = 32;

    // Load funct3 encodings (3, 6 and 7 are not loads)
    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    typedef enum logic [1:0] {
        WB_IDLE = 2'd0,
        WB_REQ  = 2'd1,
        WB_WAIT = 2'd2
    } wb_state_t;

endpackage

// File: rtl/wb_load_align.sv
// wb_load_align: selects and sign/zero-extends load data from a memory word,
// and flags whether the funct3/offset combination is a legal, aligned load.
// Latency: combinational. Backpressure: none.
// Ports: i_funct3 load type, i_offset byte offset in the word, i_rdata memory
//        word; o_data extended result, o_legal load is legal and aligned.
module wb_load_align
    import rv32_pkg::*;
(
    input  logic [2:0]      i_funct3,
    input  logic [1:0]      i_offset,
    input  logic [XLEN-1:0] i_rdata,
    output logic [XLEN-1:0] o_data,
    output logic            o_legal
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Halfword selection only looks at offset[1]; offset[0] is the misalignment bit.
    assign w_byte = i_rdata[{i_offset, 3'b000} +: 8];
    assign w_half = i_rdata[{i_offset[1], 4'b0000} +: 16];

    always_comb begin
        o_data  = '0;
        o_legal = 1'b0;
        case (i_funct3)
            F3_LB: begin
                o_data  = {{24{w_byte[7]}}, w_byte};
                o_legal = 1'b1;
            end
            F3_LBU: begin
                o_data  = {24'd0, w_byte};
                o_legal = 1'b1;
            end
            F3_LH: begin
                o_data  = {{16{w_half[15]}}, w_half};
                o_legal = ~i_offset[0];
            end
            F3_LHU: begin
                o_data  = {16'd0, w_half};
                o_legal = ~i_offset[0];
            end
            F3_LW: begin
                o_data  = i_rdata;
                o_legal = (i_offset == 2'b00);
            end
            default: begin
                o_data  = '0;
                o_legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// wb_stage: RV32I writeback; retires ALU results and runs loads against data
// memory (request, wait, align/extend) before driving the register-file port.
// Latency: ALU 1 cycle; load >= 2 cycles. Backpressure: stall_o held while a load is in flight.
// Ports: ex_* retiring instruction; dmem_* single-cycle read request/response;
//        rf_* register-file write port; misalign_o/bus_err_o one-cycle error pulses.
module wb_stage
    import rv32_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            ex_valid_i,
    input  logic [4:0]      ex_rd_i,
    input  logic [XLEN-1:0] ex_result_i,
    input  logic            ex_is_load_i,
    input  logic [2:0]      ex_funct3_i,
    output logic            dmem_req_o,
    output logic [XLEN-1:0] dmem_addr_o,
    input  logic            dmem_rvalid_i,
    input  logic [XLEN-1:0] dmem_rdata_i,
    output logic            stall_o,
    output logic            misalign_o,
    output logic            bus_err_o,
    output logic            rf_wr_en_o,
    output logic [4:0]      rf_waddr_o,
    output logic [XLEN-1:0] rf_wdata_o
);

    localparam logic [9:0] LP_CNT_LAST = 10'(TIMEOUT_CYCLES - 1);

    wb_state_t       r_state,   w_state_nxt;
    logic [9:0]      r_cnt,     w_cnt_nxt;
    logic [4:0]      r_rd,      w_rd_nxt;
    logic [2:0]      r_funct3,  w_funct3_nxt;
    logic [1:0]      r_off,     w_off_nxt;
    logic [29:0]     r_addr_hi, w_addr_hi_nxt;
    logic            r_wr_en,   w_wr_en_nxt;
    logic [4:0]      r_waddr,   w_waddr_nxt;
    logic [XLEN-1:0] r_wdata,   w_wdata_nxt;
    logic            r_mis,     w_mis_nxt;
    logic            r_berr,    w_berr_nxt;

    logic [2:0]      w_al_funct3;
    logic [1:0]      w_al_off;
    logic [XLEN-1:0] w_al_data;
    logic            w_al_legal;

    // One aligner serves both jobs: in IDLE it checks the incoming load's
    // legality; once a load is in flight it aligns the returning word.
    assign w_al_funct3 = (r_state == WB_IDLE) ? ex_funct3_i      : r_funct3;
    assign w_al_off    = (r_state == WB_IDLE) ? ex_result_i[1:0] : r_off;

    wb_load_align u_align (
        .i_funct3 (w_al_funct3),
        .i_offset (w_al_off),
        .i_rdata  (dmem_rdata_i),
        .o_data   (w_al_data),
        .o_legal  (w_al_legal)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= WB_IDLE;
            r_cnt     <= '0;
            r_rd      <= '0;
            r_funct3  <= '0;
            r_off     <= '0;
            r_addr_hi <= '0;
            r_wr_en   <= 1'b0;
            r_waddr   <= '0;
            r_wdata   <= '0;
            r_mis     <= 1'b0;
            r_berr    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_rd      <= w_rd_nxt;
            r_funct3  <= w_funct3_nxt;
            r_off     <= w_off_nxt;
            r_addr_hi <= w_addr_hi_nxt;
            r_wr_en   <= w_wr_en_nxt;
            r_waddr   <= w_waddr_nxt;
            r_wdata   <= w_wdata_nxt;
            r_mis     <= w_mis_nxt;
            r_berr    <= w_berr_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_rd_nxt      = r_rd;
        w_funct3_nxt  = r_funct3;
        w_off_nxt     = r_off;
        w_addr_hi_nxt = r_addr_hi;
        w_wr_en_nxt   = 1'b0;
        w_waddr_nxt   = r_waddr;
        w_wdata_nxt   = r_wdata;
        w_mis_nxt     = 1'b0;
        w_berr_nxt    = 1'b0;

        case (r_state)
            WB_IDLE: begin
                if (ex_valid_i) begin
                    if (!ex_is_load_i) begin
                        w_wr_en_nxt = (ex_rd_i != 5'd0);
                        w_waddr_nxt = ex_rd_i;
                        w_wdata_nxt = ex_result_i;
                    end else if (w_al_legal) begin
                        w_rd_nxt      = ex_rd_i;
                        w_funct3_nxt  = ex_funct3_i;
                        w_off_nxt     = ex_result_i[1:0];
                        w_addr_hi_nxt = ex_result_i[31:2];
                        w_state_nxt   = WB_REQ;
                    end else begin
                        w_mis_nxt = 1'b1;
                    end
                end
            end
            WB_REQ: begin
                // Zero-wait memory may answer in the request cycle itself.
                if (dmem_rvalid_i) begin
                    w_wr_en_nxt = (r_rd != 5'd0);
                    w_waddr_nxt = r_rd;
                    w_wdata_nxt = w_al_data;
                    w_state_nxt = WB_IDLE;
                end else begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = WB_WAIT;
                end
            end
            WB_WAIT: begin
                // A response in the last allowed cycle still wins over the timeout.
                if (dmem_rvalid_i) begin
                    w_wr_en_nxt = (r_rd != 5'd0);
                    w_waddr_nxt = r_rd;
                    w_wdata_nxt = w_al_data;
                    w_state_nxt = WB_IDLE;
                end else if (r_cnt == LP_CNT_LAST) begin
                    w_berr_nxt  = 1'b1;
                    w_state_nxt = WB_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 10'd1;
                end
            end
            default: begin
                w_state_nxt = WB_IDLE;
            end
        endcase
    end

    assign stall_o     = (r_state != WB_IDLE);
    assign dmem_req_o  = (r_state == WB_REQ);
    assign dmem_addr_o = {r_addr_hi, 2'b00};
    assign misalign_o  = r_mis;
    assign bus_err_o   = r_berr;
    assign rf_wr_en_o  = r_wr_en;
    assign rf_waddr_o  = r_waddr;
    assign rf_wdata_o  = r_wdata;

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed vector table, hand-written corner sequences and a
// randomized run checked against a schedule-based reference model.
module tb_wb_stage;

    localparam int TMO = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        ex_valid_i;
    logic [4:0]  ex_rd_i;
    logic [31:0] ex_result_i;
    logic        ex_is_load_i;
    logic [2:0]  ex_funct3_i;
    logic        dmem_req_o;
    logic [31:0] dmem_addr_o;
    logic        dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
    logic        stall_o;
    logic        misalign_o;
    logic        bus_err_o;
    logic        rf_wr_en_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;

    always #5 clk_i = ~clk_i;

    wb_stage #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .ex_valid_i    (ex_valid_i),
        .ex_rd_i       (ex_rd_i),
        .ex_result_i   (ex_result_i),
        .ex_is_load_i  (ex_is_load_i),
        .ex_funct3_i   (ex_funct3_i),
        .dmem_req_o    (dmem_req_o),
        .dmem_addr_o   (dmem_addr_o),
        .dmem_rvalid_i (dmem_rvalid_i),
        .dmem_rdata_i  (dmem_rdata_i),
        .stall_o       (stall_o),
        .misalign_o    (misalign_o),
        .bus_err_o     (bus_err_o),
        .rf_wr_en_o    (rf_wr_en_o),
        .rf_waddr_o    (rf_waddr_o),
        .rf_wdata_o    (rf_wdata_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // ---------------- reference model (arithmetic on the load rules) -------
    function automatic bit m_legal(input logic [2:0] f3, input logic [31:0] a);
        case (f3)
            3'd0, 3'd4: return 1'b1;
            3'd1, 3'd5: return (a % 2) == 0;
            3'd2:       return (a % 4) == 0;
            default:    return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] m_align(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] w);
        logic [31:0] v;
        v = w;
        if (f3 == 3'd0 || f3 == 3'd4) begin
            v = (w >> (8 * (a % 4))) & 32'h0000_00FF;
            if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
        end else if (f3 == 3'd1 || f3 == 3'd5) begin
            v = (w >> (16 * ((a % 4) / 2))) & 32'h0000_FFFF;
            if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
        end
        return v;
    endfunction

    // ---------------- directed vectors -------------------------------------
    typedef struct {
        bit          ld;
        logic [4:0]  rd;
        logic [31:0] res;
        logic [2:0]  f3;
        logic [31:0] rdata;
        int          lat;      // cycles after the request cycle that rvalid arrives
        int          e_wr;     // number of rf_wr_en_o pulses
        int          e_wcyc;   // cycle (after issue) in which rf_wr_en_o is seen
        logic [31:0] e_wd;
        int          e_mis;
        int          e_berr;
        int          e_req;
        logic [31:0] e_addr;
        int          e_stall;
    } vec_t;

    vec_t vt[$];

    task automatic run_vec(input vec_t v, output int n_wr, output int wcyc,
                           output logic [4:0] wa, output logic [31:0] wd,
                           output int n_mis, output int n_berr, output int n_req,
                           output logic [31:0] addr, output int n_stall);
        n_wr = 0; wcyc = -1; wa = '0; wd = '0;
        n_mis = 0; n_berr = 0; n_req = 0; addr = '0; n_stall = 0;
        @(posedge clk_i); #1;
        ex_valid_i    = 1'b1;
        ex_rd_i       = v.rd;
        ex_result_i   = v.res;
        ex_is_load_i  = v.ld;
        ex_funct3_i   = v.f3;
        dmem_rvalid_i = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            @(posedge clk_i); #1;
            ex_valid_i    = 1'b0;
            dmem_rvalid_i = v.ld && (n == 1 + v.lat);
            dmem_rdata_i  = v.rdata;
            @(negedge clk_i);
            if (stall_o)    n_stall++;
            if (dmem_req_o) begin n_req++; addr = dmem_addr_o; end
            if (rf_wr_en_o) begin n_wr++; wcyc = n; wa = rf_waddr_o; wd = rf_wdata_o; end
            if (misalign_o) n_mis++;
            if (bus_err_o)  n_berr++;
        end
        dmem_rvalid_i = 1'b0;
    endtask

    // ---------------- random phase state -----------------------------------
    bit          exp_wr[int];
    logic [4:0]  exp_wa[int];
    logic [31:0] exp_wd[int];
    bit          exp_mis[int];
    bit          exp_berr[int];
    bit          exp_req[int];
    logic [31:0] exp_addr[int];
    int          busy_last;
    int          rv_cyc;
    int          lat;
    bit          m_stall;
    bit          t_v, t_ld;
    logic [4:0]  t_rd;
    logic [31:0] t_res, cur_rdata;
    logic [2:0]  t_f3;
    logic [2:0]  legal_f3 [5];

    int          o_wr, o_wcyc, o_mis, o_berr, o_req, o_stall;
    logic [4:0]  o_wa;
    logic [31:0] o_wd, o_addr;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1;
        ex_valid_i = 1'b0; ex_rd_i = '0; ex_result_i = '0; ex_is_load_i = 1'b0;
        ex_funct3_i = '0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
        legal_f3[0] = 3'd0; legal_f3[1] = 3'd1; legal_f3[2] = 3'd2;
        legal_f3[3] = 3'd4; legal_f3[4] = 3'd5;

        //         ld    rd     res            f3    rdata          lat wr wcyc wd            mis berr req addr          stall
        vt.push_back('{1'b0, 5'd5,  32'h1234_5678, 3'd0, 32'h0,         99, 1, 1, 32'h1234_5678, 0, 0, 0, 32'h0,         0});
        vt.push_back('{1'b0, 5'd6,  32'hDEAD_BEEF, 3'd0, 32'h0,         99, 1, 1, 32'hDEAD_BEEF, 0, 0, 0, 32'h0,         0});
        vt.push_back('{1'b1, 5'd7,  32'h0000_1003, 3'd0, 32'h80FF_0000, 3,  1, 5, 32'hFFFF_FF80, 0, 0, 1, 32'h0000_1000, 4});
        vt.push_back('{1'b1, 5'd8,  32'h0000_2002, 3'd5, 32'hBEEF_1234, 0,  1, 2, 32'h0000_BEEF, 0, 0, 1, 32'h0000_2000, 1});
        vt.push_back('{1'b1, 5'd9,  32'h0000_3001, 3'd2, 32'h0,         0,  0, -1, 32'h0,        1, 0, 0, 32'h0,         0});
        vt.push_back('{1'b1, 5'd9,  32'h0000_3003, 3'd1, 32'h0,         0,  0, -1, 32'h0,        1, 0, 0, 32'h0,         0});
        vt.push_back('{1'b1, 5'd10, 32'h0000_4000, 3'd2, 32'h0,         99, 0, -1, 32'h0,        0, 1, 1, 32'h0000_4000, 5});
        vt.push_back('{1'b0, 5'd11, 32'h0000_0077, 3'd0, 32'h0,         99, 1, 1, 32'h0000_0077, 0, 0, 0, 32'h0,         0});
        vt.push_back('{1'b0, 5'd0,  32'h0000_0055, 3'd0, 32'h0,         99, 0, -1, 32'h0,        0, 0, 0, 32'h0,         0});
        vt.push_back('{1'b1, 5'd0,  32'h0000_5008, 3'd2, 32'hCAFE_F00D, 1,  0, -1, 32'h0,        0, 0, 1, 32'h0000_5008, 2});
        vt.push_back('{1'b1, 5'd12, 32'h0000_0100, 3'd3, 32'h0,         0,  0, -1, 32'h0,        1, 0, 0, 32'h0,         0});
        vt.push_back('{1'b1, 5'd13, 32'h0000_6001, 3'd4, 32'h0000_8000, 2,  1, 4, 32'h0000_0080, 0, 0, 1, 32'h0000_6000, 3});
        vt.push_back('{1'b1, 5'd14, 32'h0000_6002, 3'd1, 32'h8001_0000, 0,  1, 2, 32'hFFFF_8001, 0, 0, 1, 32'h0000_6000, 1});
        vt.push_back('{1'b1, 5'd15, 32'h0000_7000, 3'd0, 32'h0000_007F, 4,  1, 6, 32'h0000_007F, 0, 0, 1, 32'h0000_7000, 5});

        // ---- reset state ----
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_req",   32'(dmem_req_o), 32'd0);
        chk("rst_addr",  dmem_addr_o, 32'd0);
        chk("rst_wr",    32'(rf_wr_en_o), 32'd0);
        chk("rst_waddr", 32'(rf_waddr_o), 32'd0);
        chk("rst_wdata", rf_wdata_o, 32'd0);
        chk("rst_mis",   32'(misalign_o), 32'd0);
        chk("rst_berr",  32'(bus_err_o), 32'd0);
        rst_i = 1'b0;

        // ---- directed table ----
        foreach (vt[i]) begin
            run_vec(vt[i], o_wr, o_wcyc, o_wa, o_wd, o_mis, o_berr, o_req, o_addr, o_stall);
            chk($sformatf("v%0d_wr_count", i), 32'(o_wr), 32'(vt[i].e_wr));
            if (vt[i].e_wr != 0) begin
                chk($sformatf("v%0d_wr_cycle", i), 32'(o_wcyc), 32'(vt[i].e_wcyc));
                chk($sformatf("v%0d_waddr", i), 32'(o_wa), 32'(vt[i].rd));
                chk($sformatf("v%0d_wdata", i), o_wd, vt[i].e_wd);
            end
            chk($sformatf("v%0d_mis_count", i), 32'(o_mis), 32'(vt[i].e_mis));
            chk($sformatf("v%0d_berr_count", i), 32'(o_berr), 32'(vt[i].e_berr));
            chk($sformatf("v%0d_req_count", i), 32'(o_req), 32'(vt[i].e_req));
            if (vt[i].e_req != 0)
                chk($sformatf("v%0d_addr", i), o_addr, vt[i].e_addr);
            chk($sformatf("v%0d_stall_cycles", i), 32'(o_stall), 32'(vt[i].e_stall));
        end

        // ---- back-to-back ALU retirement ----
        @(posedge clk_i); #1;
        ex_valid_i = 1'b1; ex_is_load_i = 1'b0; ex_rd_i = 5'd5; ex_result_i = 32'h1234_5678;
        @(posedge clk_i); #1;
        ex_rd_i = 5'd6; ex_result_i = 32'hDEAD_BEEF;
        @(negedge clk_i);
        chk("b2b_wr0", 32'(rf_wr_en_o), 32'd1);
        chk("b2b_waddr0", 32'(rf_waddr_o), 32'd5);
        chk("b2b_wdata0", rf_wdata_o, 32'h1234_5678);
        chk("b2b_stall0", 32'(stall_o), 32'd0);
        @(posedge clk_i); #1;
        ex_valid_i = 1'b0;
        @(negedge clk_i);
        chk("b2b_wr1", 32'(rf_wr_en_o), 32'd1);
        chk("b2b_waddr1", 32'(rf_waddr_o), 32'd6);
        chk("b2b_wdata1", rf_wdata_o, 32'hDEAD_BEEF);
        chk("b2b_stall1", 32'(stall_o), 32'd0);
        @(posedge clk_i); #1;
        @(negedge clk_i);
        chk("b2b_wr_done", 32'(rf_wr_en_o), 32'd0);

        // ---- reset while waiting for a load ----
        @(posedge clk_i); #1;
        ex_valid_i = 1'b1; ex_is_load_i = 1'b1; ex_rd_i = 5'd12;
        ex_result_i = 32'h0000_7000; ex_funct3_i = 3'd2; dmem_rvalid_i = 1'b0;
        @(posedge clk_i); #1;
        ex_valid_i = 1'b0;
        @(negedge clk_i);
        chk("rw_req", 32'(dmem_req_o), 32'd1);
        @(posedge clk_i); #1;
        @(negedge clk_i);
        chk("rw_wait_stall", 32'(stall_o), 32'd1);
        chk("rw_wait_req", 32'(dmem_req_o), 32'd0);
        #2 rst_i = 1'b1;
        #1;
        chk("rw_rst_stall", 32'(stall_o), 32'd0);
        chk("rw_rst_addr", dmem_addr_o, 32'd0);
        chk("rw_rst_waddr", 32'(rf_waddr_o), 32'd0);
        chk("rw_rst_wdata", rf_wdata_o, 32'd0);
        @(posedge clk_i); #1;
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk_i); #1;
            dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h1111_1111;
            @(negedge clk_i);
            chk($sformatf("late_rv_wr%0d", k), 32'(rf_wr_en_o), 32'd0);
            chk($sformatf("late_rv_stall%0d", k), 32'(stall_o), 32'd0);
        end
        dmem_rvalid_i = 1'b0;

        // ---- randomized run against the schedule model ----
        busy_last = -1;
        rv_cyc    = -1;
        for (int c = 0; c < 600; c++) begin
            @(posedge clk_i); #1;
            m_stall = (c <= busy_last);
            t_v   = ($urandom_range(0, 3) != 0);
            t_ld  = 1'($urandom_range(0, 1));
            t_rd  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            t_res = $urandom;
            t_f3  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7))
                                                : legal_f3[$urandom_range(0, 4)];
            ex_valid_i = t_v; ex_is_load_i = t_ld; ex_rd_i = t_rd;
            ex_result_i = t_res; ex_funct3_i = t_f3;
            if (c == rv_cyc) begin
                dmem_rvalid_i = 1'b1; dmem_rdata_i = cur_rdata;
            end else if (!m_stall) begin
                dmem_rvalid_i = 1'($urandom_range(0, 1)); dmem_rdata_i = $urandom;
            end else begin
                dmem_rvalid_i = 1'b0; dmem_rdata_i = $urandom;
            end

            if (!m_stall && t_v) begin
                if (!t_ld) begin
                    if (t_rd != 5'd0) begin
                        exp_wr[c+1] = 1'b1; exp_wa[c+1] = t_rd; exp_wd[c+1] = t_res;
                    end
                end else if (m_legal(t_f3, t_res)) begin
                    lat = $urandom_range(0, 6);
                    cur_rdata = $urandom;
                    exp_req[c+1]  = 1'b1;
                    exp_addr[c+1] = t_res - (t_res % 4);
                    if (lat <= TMO) begin
                        rv_cyc    = c + 1 + lat;
                        busy_last = c + 1 + lat;
                        if (t_rd != 5'd0) begin
                            exp_wr[c+2+lat] = 1'b1;
                            exp_wa[c+2+lat] = t_rd;
                            exp_wd[c+2+lat] = m_align(t_f3, t_res, cur_rdata);
                        end
                    end else begin
                        rv_cyc    = -1;
                        busy_last = c + 1 + TMO;
                        exp_berr[c+2+TMO] = 1'b1;
                    end
                end else begin
                    exp_mis[c+1] = 1'b1;
                end
            end

            @(negedge clk_i);
            chk($sformatf("rnd%0d_stall", c), 32'(stall_o), 32'(m_stall));
            chk($sformatf("rnd%0d_wr", c), 32'(rf_wr_en_o), 32'(exp_wr.exists(c)));
            if (exp_wr.exists(c)) begin
                chk($sformatf("rnd%0d_waddr", c), 32'(rf_waddr_o), 32'(exp_wa[c]));
                chk($sformatf("rnd%0d_wdata", c), rf_wdata_o, exp_wd[c]);
            end
            chk($sformatf("rnd%0d_mis", c), 32'(misalign_o), 32'(exp_mis.exists(c)));
            chk($sformatf("rnd%0d_berr", c), 32'(bus_err_o), 32'(exp_berr.exists(c)));
            chk($sformatf("rnd%0d_req", c), 32'(dmem_req_o), 32'(exp_req.exists(c)));
            if (exp_req.exists(c))
                chk($sformatf("rnd%0d_addr", c), dmem_addr_o, exp_addr[c]);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
